// File: rtl/bpred_table_writer_pkg.sv
// rtl/bpred_table_writer_pkg.sv - shared predictor-table state encoding, counter constants and saturation helpers
package bpred_table_writer_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } wr_state_t;

    localparam int CTR_BITS_DEF = 2;
    localparam int CTR_MIN      = 0;
    localparam int CTR_MAX      = (1 << CTR_BITS_DEF) - 1;
    localparam int INIT_VAL_DEF = 1;

    function automatic int ctr_max(input int dbits);
        return (1 << dbits) - 1;
    endfunction

    // Callers pass the counter zero-extended by one bit, so value+1 never wraps.
    function automatic int sat_inc(input int value, input int dbits);
        if (value >= ctr_max(dbits)) begin
            return ctr_max(dbits);
        end
        return value + 1;
    endfunction

    function automatic int sat_dec(input int value);
        if (value <= CTR_MIN) begin
            return CTR_MIN;
        end
        return value - 1;
    endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// rtl/bpred_upd_fifo.sv - synchronous update FIFO holding {addr, taken}, flushed by reset
module bpred_upd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int          PW        = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/bpred_table_writer.sv
// rtl/bpred_table_writer.sv - predictor table write engine: init sweep, saturating updates, direct loads
module bpred_table_writer
    import bpred_table_writer_pkg::*;
#(
    parameter int DBITS    = CTR_BITS_DEF,
    parameter int ABITS    = 8,
    parameter int WORDS    = 1 << ABITS,
    parameter int INIT_VAL = INIT_VAL_DEF,
    parameter int QDEPTH   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             UPD_VALID,
    output logic             UPD_READY,
    input  logic [ABITS-1:0] UPD_ADDR,
    input  logic             UPD_TAKEN,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [ABITS-1:0] LD_ADDR,
    input  logic [DBITS-1:0] LD_DATA,
    output logic             BUSY,
    output logic [ABITS-1:0] TBL_RADDR,
    input  logic [DBITS-1:0] TBL_RDATA,
    output logic [ABITS-1:0] TBL_WADDR,
    output logic [DBITS-1:0] TBL_WDATA,
    output logic             TBL_WE
);

    localparam int               QW        = ABITS + 1;
    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(WORDS - 1);

    wr_state_t        state_q;
    wr_state_t        state_d;
    logic [ABITS-1:0] sweep_ptr;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [QW-1:0]    fifo_head;
    logic [ABITS-1:0] head_addr;
    logic             head_taken;

    logic [DBITS:0]   ctr_ext;
    logic [DBITS-1:0] ctr_next;

    assign UPD_READY = !RESET && !fifo_full;
    assign fifo_push = UPD_VALID && UPD_READY;
    assign {head_addr, head_taken} = fifo_head;

    // The read port always tracks the FIFO head so the update can complete in one cycle.
    assign TBL_RADDR = fifo_empty ? '0 : head_addr;
    assign ctr_ext   = {1'b0, TBL_RDATA};
    assign ctr_next  = head_taken ? DBITS'(sat_inc(int'(ctr_ext), DBITS))
                                  : DBITS'(sat_dec(int'(ctr_ext)));

    bpred_upd_fifo #(
        .WIDTH (QW),
        .DEPTH (QDEPTH)
    ) u_upd_fifo (
        .clk       (CLK),
        .reset     (RESET),
        .push      (fifo_push),
        .push_data ({UPD_ADDR, UPD_TAKEN}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                sweep_ptr <= sweep_ptr + ABITS'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        TBL_WE    = 1'b0;
        TBL_WADDR = '0;
        TBL_WDATA = '0;
        BUSY      = 1'b0;
        LD_READY  = 1'b0;
        fifo_pop  = 1'b0;
        if (RESET) begin
            BUSY = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    BUSY      = 1'b1;
                    TBL_WE    = 1'b1;
                    TBL_WADDR = sweep_ptr;
                    TBL_WDATA = DBITS'(INIT_VAL);
                    if (sweep_ptr == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    LD_READY = 1'b1;
                    // A load wins the write port; the queued update waits a cycle.
                    if (LD_VALID) begin
                        TBL_WE    = 1'b1;
                        TBL_WADDR = LD_ADDR;
                        TBL_WDATA = LD_DATA;
                    end else if (!fifo_empty) begin
                        TBL_WE    = 1'b1;
                        TBL_WADDR = head_addr;
                        TBL_WDATA = ctr_next;
                        fifo_pop  = 1'b1;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_bpred_table_writer.sv
// tb/tb_bpred_table_writer.sv - scoreboard bench for the branch-predictor table writer
module tb_bpred_table_writer;

    localparam int DBITS  = 2;
    localparam int ABITS  = 3;
    localparam int WORDS  = 8;
    localparam int QDEPTH = 4;

    typedef struct packed {
        logic [ABITS-1:0] addr;
        logic [DBITS-1:0] data;
    } wr_t;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             UPD_VALID;
    logic             UPD_READY;
    logic [ABITS-1:0] UPD_ADDR;
    logic             UPD_TAKEN;
    logic             LD_VALID;
    logic             LD_READY;
    logic [ABITS-1:0] LD_ADDR;
    logic [DBITS-1:0] LD_DATA;
    logic             BUSY;
    logic [ABITS-1:0] TBL_RADDR;
    logic [DBITS-1:0] TBL_RDATA;
    logic [ABITS-1:0] TBL_WADDR;
    logic [DBITS-1:0] TBL_WDATA;
    logic             TBL_WE;

    logic [DBITS-1:0] tbl [WORDS];
    wr_t              sb [$];
    int               n_cmp  = 0;
    int               n_fail = 0;

    int inc_seq [7] = '{2, 3, 3, 3, 2, 1, 0};
    int bp_tkn  [6] = '{1, 0, 1, 1, 0, 0};

    bpred_table_writer #(
        .DBITS    (DBITS),
        .ABITS    (ABITS),
        .WORDS    (WORDS),
        .INIT_VAL (1),
        .QDEPTH   (QDEPTH)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .UPD_VALID (UPD_VALID),
        .UPD_READY (UPD_READY),
        .UPD_ADDR  (UPD_ADDR),
        .UPD_TAKEN (UPD_TAKEN),
        .LD_VALID  (LD_VALID),
        .LD_READY  (LD_READY),
        .LD_ADDR   (LD_ADDR),
        .LD_DATA   (LD_DATA),
        .BUSY      (BUSY),
        .TBL_RADDR (TBL_RADDR),
        .TBL_RDATA (TBL_RDATA),
        .TBL_WADDR (TBL_WADDR),
        .TBL_WDATA (TBL_WDATA),
        .TBL_WE    (TBL_WE)
    );

    always #5 CLK = ~CLK;

    // Table model: synchronous write, asynchronous read.
    always @(posedge CLK) begin
        if (TBL_WE === 1'b1) begin
            tbl[TBL_WADDR] <= TBL_WDATA;
        end
    end
    assign TBL_RDATA = tbl[TBL_RADDR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int a, input int d);
        wr_t e;
        e.addr = ABITS'(a);
        e.data = DBITS'(d);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge CLK);
        check({tag, "_we"},        32'(TBL_WE),    32'd0);
        check({tag, "_busy"},      32'(BUSY),      32'd1);
        check({tag, "_upd_ready"}, 32'(UPD_READY), 32'd0);
        check({tag, "_ld_ready"},  32'(LD_READY),  32'd0);
    endtask

    // Monitor: every table write must match the next expected write in order.
    always @(negedge CLK) begin
        wr_t e;
        if (TBL_WE === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write (t=%0t)",
                         TBL_WADDR, TBL_WDATA, $time);
            end else begin
                e = sb.pop_front();
                check("write_addr", 32'(TBL_WADDR), 32'(e.addr));
                check("write_data", 32'(TBL_WDATA), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        UPD_VALID = 1'b0;
        UPD_ADDR  = '0;
        UPD_TAKEN = 1'b0;
        LD_VALID  = 1'b0;
        LD_ADDR   = '0;
        LD_DATA   = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        tick();

        // Sweep: 8 writes of 1, BUSY drops on the 9th cycle.
        for (int a = 0; a < WORDS; a++) push_exp(a, 1);
        RESET = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            @(negedge CLK);
            check("sweep_busy", 32'(BUSY), 32'd1);
            tick();
        end
        @(negedge CLK);
        check("busy_fall", 32'(BUSY), 32'd0);
        check("ld_ready_idle", 32'(LD_READY), 32'd1);
        check("idle_empty_we", 32'(TBL_WE), 32'd0);
        tick();
        wait_drain("sweep_drain");
        for (int a = 0; a < WORDS; a++) check("tbl_init", 32'(tbl[ABITS'(a)]), 32'd1);

        // Saturating increment then decrement on addr 5, one write per cycle.
        for (int i = 0; i < 7; i++) begin
            UPD_VALID = 1'b1;
            UPD_ADDR  = ABITS'(5);
            UPD_TAKEN = (i < 4);
            push_exp(5, inc_seq[i]);
            @(negedge CLK);
            check("sat_upd_ready", 32'(UPD_READY), 32'd1);
            if (i == 0) check("no_bypass", 32'(TBL_WE), 32'd0);
            else        check("sat_we_consecutive", 32'(TBL_WE), 32'd1);
            tick();
        end
        UPD_VALID = 1'b0;
        @(negedge CLK);
        check("sat_last_we", 32'(TBL_WE), 32'd1);
        tick();
        @(negedge CLK);
        check("sat_done_we", 32'(TBL_WE), 32'd0);
        tick();
        wait_drain("sat_drain");
        check("sat_final", 32'(tbl[ABITS'(5)]), 32'd0);

        // Backpressure during init: 6 offered, 4 accepted, drained after the sweep.
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        for (int a = 0; a < WORDS; a++) push_exp(a, 1);
        for (int k = 0; k < 6; k++) begin
            UPD_VALID = 1'b1;
            UPD_ADDR  = ABITS'(k);
            UPD_TAKEN = bp_tkn[k][0];
            @(negedge CLK);
            check("bp_busy", 32'(BUSY), 32'd1);
            check("bp_upd_ready", 32'(UPD_READY), (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) push_exp(k, (bp_tkn[k] != 0) ? 2 : 0);
            tick();
        end
        UPD_VALID = 1'b0;
        wait_drain("bp_drain");
        @(negedge CLK);
        check("bp_ready_back", 32'(UPD_READY), 32'd1);
        tick();

        // Load priority: queued update to addr 2 waits behind a load of 0.
        push_exp(2, 0);
        push_exp(2, 1);
        UPD_VALID = 1'b1;
        UPD_ADDR  = ABITS'(2);
        UPD_TAKEN = 1'b1;
        @(negedge CLK);
        check("ld_pre_we", 32'(TBL_WE), 32'd0);
        tick();
        UPD_VALID = 1'b0;
        LD_VALID  = 1'b1;
        LD_ADDR   = ABITS'(2);
        LD_DATA   = DBITS'(0);
        @(negedge CLK);
        check("ld_ready", 32'(LD_READY), 32'd1);
        tick();
        LD_VALID = 1'b0;
        wait_drain("ld_drain");
        check("ld_final", 32'(tbl[ABITS'(2)]), 32'd1);

        // Mid-stream reset with ptr at 4 and 3 updates queued.
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        for (int a = 0; a < 4; a++) push_exp(a, 1);
        for (int k = 0; k < 4; k++) begin
            UPD_VALID = (k < 3);
            UPD_ADDR  = ABITS'(6 + k);
            UPD_TAKEN = 1'b1;
            tick();
        end
        UPD_VALID = 1'b0;
        RESET     = 1'b1;
        check("mid_partial_drain", 32'(sb.size()), 32'd0);
        check_reset_outputs("mid_reset");
        tick();
        tick();
        RESET = 1'b0;
        for (int a = 0; a < WORDS; a++) push_exp(a, 1);
        wait_drain("mid_sweep_drain");
        repeat (10) tick();
        for (int a = 0; a < WORDS; a++) check("mid_tbl", 32'(tbl[ABITS'(a)]), 32'd1);

        // Full push/pop: occupancy held at 3 by a simultaneous push and pop.
        push_exp(7, 3);
        push_exp(6, 0);
        push_exp(5, 2);
        push_exp(0, 2);
        push_exp(4, 3);
        push_exp(1, 0);
        push_exp(2, 2);
        push_exp(3, 2);
        push_exp(4, 2);
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin LD_VALID = 1'b1; LD_ADDR = 3'd7; LD_DATA = 2'd3; UPD_VALID = 1'b1; UPD_ADDR = 3'd0; UPD_TAKEN = 1'b1; end
                1: begin LD_VALID = 1'b1; LD_ADDR = 3'd6; LD_DATA = 2'd0; UPD_VALID = 1'b1; UPD_ADDR = 3'd1; UPD_TAKEN = 1'b0; end
                2: begin LD_VALID = 1'b1; LD_ADDR = 3'd5; LD_DATA = 2'd2; UPD_VALID = 1'b1; UPD_ADDR = 3'd2; UPD_TAKEN = 1'b1; end
                3: begin LD_VALID = 1'b0;                                UPD_VALID = 1'b1; UPD_ADDR = 3'd3; UPD_TAKEN = 1'b1; end
                4: begin LD_VALID = 1'b1; LD_ADDR = 3'd4; LD_DATA = 2'd3; UPD_VALID = 1'b1; UPD_ADDR = 3'd4; UPD_TAKEN = 1'b0; end
                default: begin LD_VALID = 1'b0; UPD_VALID = 1'b0; end
            endcase
            @(negedge CLK);
            if (c == 3) check("pushpop_ready", 32'(UPD_READY), 32'd1);
            if (c == 4) check("occ3_ready", 32'(UPD_READY), 32'd1);
            if (c == 5) check("occ4_full", 32'(UPD_READY), 32'd0);
            tick();
        end
        wait_drain("pushpop_drain");
        @(negedge CLK);
        check("pushpop_ready_back", 32'(UPD_READY), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bpred_table_writer.md
Name: bpred_table_writer

Overview:
- Write-side engine for the synchronous-write / asynchronous-read table memory used by the branch predictor.
- After reset it sweeps every entry to a known initial value.
- After the sweep it performs single-cycle read-modify-write saturating-counter updates from a buffered resolution stream, plus direct loads from a fill/debug port.
- It is the only driver of the table's write port and of a dedicated write-side copy of the table's read port.

Parameters:
- DBITS, 2, counter width per entry.
- ABITS, 8, table address width.
- WORDS, 1<<ABITS, number of entries swept at init.
- INIT_VAL, 1, value written to every entry during the sweep (weakly not-taken).
- QDEPTH, 4, update FIFO depth (power of two, >=2).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- UPD_VALID  in  1  resolution update offered.
- UPD_READY  out  1  update accepted when UPD_VALID&UPD_READY at CLK edge.
- UPD_ADDR  in  ABITS  entry to update.
- UPD_TAKEN  in  1  1 = increment counter, 0 = decrement.
- LD_VALID  in  1  direct load request, single-cycle, no backpressure beyond LD_READY.
- LD_READY  out  1  high only in IDLE state.
- LD_ADDR  in  ABITS  load address.
- LD_DATA  in  DBITS  load value.
- BUSY  out  1  init sweep in progress.
- TBL_RADDR  out  ABITS  write-side table read address.
- TBL_RDATA  in  DBITS  asynchronous read data for TBL_RADDR, same cycle.
- TBL_WADDR  out  ABITS  table write address.
- TBL_WDATA  out  DBITS  table write data.
- TBL_WE  out  1  table write enable, sampled by table at CLK edge.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET). RESET sampled high at an edge puts the block in INIT with sweep pointer 0 and the FIFO flushed.
- While RESET is high: TBL_WE=0, BUSY=1, UPD_READY=0, LD_READY=0.
- States:
  - INIT: TBL_WE=1, TBL_WADDR=ptr, TBL_WDATA=INIT_VAL every cycle RESET is low; ptr increments each edge. The edge that writes ptr==WORDS-1 moves the block to IDLE. The sweep lasts exactly WORDS cycles; BUSY=1 throughout and drops in the first IDLE cycle.
  - IDLE: BUSY=0, LD_READY=1.
    - If LD_VALID=1: TBL_WE=1, TBL_WADDR=LD_ADDR, TBL_WDATA=LD_DATA. No FIFO pop that cycle; the load has priority.
    - Otherwise, if the FIFO is non-empty: TBL_RADDR=head addr. TBL_WDATA = sat(TBL_RDATA ±1), where +1 if head taken and -1 otherwise. TBL_WADDR=head addr, TBL_WE=1, and the head is popped at the edge.
    - Otherwise TBL_WE=0.
- Saturation: the value stays at 2^DBITS-1 on increment and at 0 on decrement. Arithmetic is DBITS+1 wide internally, clamped to DBITS.
- TBL_RADDR equals the head addr whenever the FIFO is non-empty, in any state; otherwise 0.
- Back-to-back updates to the same address need no hazard logic: the table write lands at the edge, so the next cycle's asynchronous read returns the new value.
- FIFO:
  - UPD_READY = !full when RESET=0. Updates are accepted during INIT and queue until IDLE.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - There is no same-cycle bypass: an update is written no earlier than the cycle after acceptance.
  - Pointers wrap modulo QDEPTH; occupancy counter is clog2(QDEPTH)+1 bits.
- RESET mid-sweep or mid-stream: queued updates are discarded, the sweep restarts at 0, and any partially updated table contents are overwritten by the sweep.
- LD_VALID while LD_READY=0 is ignored; the requester must hold it.
- Latency: update accepted at edge N, written at edge N+1 at the earliest (IDLE, no load, FIFO empty before the push).

Decomposition:
- Shared predictor package holds:
  - state encoding constants INIT/IDLE;
  - counter constants CTR_MAX, CTR_MIN, INIT_VAL default;
  - sat_inc / sat_dec helper functions.
- One sub-module: bpred_upd_fifo, a parameterised synchronous FIFO with full/empty, push/pop and flush-on-RESET, storing {addr, taken}.

Test Plan (ABITS=3, DBITS=2, QDEPTH=4, table model attached):
- Sweep: deassert RESET -> TBL_WE=1 for exactly 8 cycles with addresses 0..7, data 1; BUSY falls on cycle 9; all table entries equal 1.
- Saturating increment: 4 updates to addr 5 taken=1 in consecutive cycles -> entry sequence 2,3,3,3 and TBL_WE pulses on 4 consecutive cycles; 3 updates taken=0 then give 2,1,0.
- Backpressure during init: offer 6 updates while BUSY -> first 4 accepted, UPD_READY=0 afterwards; after the sweep they drain in order, one per cycle, and UPD_READY returns high.
- Load priority: FIFO holds addr 2 taken=1 while LD_VALID with addr 2, data 0 -> cycle 1 writes 0 via the load, cycle 2 writes 1 via the update.
- Mid-stream reset: assert RESET with 3 updates queued and ptr at 4 -> no writes while RESET is high; after release the sweep restarts at 0 and none of the 3 updates is ever written.
- Full push/pop: FIFO at 3 entries, simultaneous push and pop -> occupancy stays 3 and write order is preserved.
